// File: rtl/seven_seg_mux_ctrl_if.sv
// seven_seg_mux_ctrl_if: display data/strobe inputs and anode/cathode outputs of the seven-segment controller.
//   digits_in/dp_in/blank_in/brightness/load : system side, captured on load
//   anode_sel/seven_seg/frame_done           : board side, active-low pins and scan pulse
interface seven_seg_mux_ctrl_if #(parameter int NUM_DIGITS = 4);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic [3:0]              brightness;
    logic                    load;
    logic [NUM_DIGITS-1:0]   anode_sel;
    logic [7:0]              seven_seg;
    logic                    frame_done;
    modport master (output digits_in, dp_in, blank_in, brightness, load,
                    input  anode_sel, seven_seg, frame_done);
    modport slave  (input  digits_in, dp_in, blank_in, brightness, load,
                    output anode_sel, seven_seg, frame_done);
endinterface

// File: rtl/seven_seg_mux_ctrl.sv
// seven_seg_mux_ctrl: time-multiplexed common-anode seven-segment driver with hex decode, dp, blanking,
// 16-level PWM and double-buffered (frame-aligned) updates.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : seven_seg_mux_ctrl_if.slave (inputs captured on load; registered anode/cathode/frame_done)
//   SSEG_LZ_SUPPRESS_EN : when defined, leading zeros (value 0, dp off) above digit 0 are blanked
module seven_seg_mux_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    seven_seg_mux_ctrl_if.slave bus
);
    localparam int sw = $clog2(REFRESH_DIV);
    localparam int iw = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int pw = REFRESH_DIV / 16;
    localparam logic [6:0] seg_tbl [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic [sw-1:0]           slot_cnt;
    logic [iw-1:0]           digit_idx;
    logic [4*NUM_DIGITS-1:0] p_digits, a_digits;
    logic [NUM_DIGITS-1:0]   p_dp, a_dp, p_blank, a_blank;
    logic [3:0]              p_bright, a_bright;
    logic                    slot_wrap, boundary, lit;
    logic [sw-1:0]           phase;
    logic [3:0]              nib;
    logic [NUM_DIGITS-1:0]   lz, dark, anode_d;
    logic [7:0]              seg_d;

    assign slot_wrap = slot_cnt == sw'(REFRESH_DIV - 1);
    assign boundary  = slot_wrap && digit_idx == iw'(NUM_DIGITS - 1);
    assign phase     = slot_cnt / sw'(pw);
    assign nib       = a_digits[digit_idx*4 +: 4];

`ifdef SSEG_LZ_SUPPRESS_EN
    logic zrun;
    // Walk down from the top digit while digits stay 0 with dp off; digit 0 is never examined.
    always_comb begin
        lz   = '0;
        zrun = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zrun  = zrun && a_digits[4*i +: 4] == 4'h0 && !a_dp[i];
            lz[i] = zrun;
        end
    end
`else
    assign lz = '0;
`endif

    assign dark    = a_blank | lz;
    assign lit     = phase < sw'(a_bright) && !dark[digit_idx];
    assign anode_d = lit ? ~(NUM_DIGITS'(1) << digit_idx) : '1;
    assign seg_d   = lit ? {~a_dp[digit_idx], seg_tbl[nib]} : 8'hFF;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt       <= '0;
            digit_idx      <= '0;
            p_digits       <= '0;
            a_digits       <= '0;
            p_dp           <= '0;
            a_dp           <= '0;
            p_blank        <= '1;
            a_blank        <= '1;
            p_bright       <= '0;
            a_bright       <= '0;
            bus.anode_sel  <= '1;
            bus.seven_seg  <= 8'hFF;
            bus.frame_done <= 1'b0;
        end else begin
            slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
            if (slot_wrap)
                digit_idx <= digit_idx == iw'(NUM_DIGITS - 1) ? '0 : digit_idx + 1'b1;
            if (bus.load) begin
                p_digits <= bus.digits_in;
                p_dp     <= bus.dp_in;
                p_blank  <= bus.blank_in;
                p_bright <= bus.brightness;
            end
            // A load landing on the boundary bypasses pending so it is not delayed a whole frame.
            if (boundary) begin
                a_digits <= bus.load ? bus.digits_in  : p_digits;
                a_dp     <= bus.load ? bus.dp_in      : p_dp;
                a_blank  <= bus.load ? bus.blank_in   : p_blank;
                a_bright <= bus.load ? bus.brightness : p_bright;
            end
            bus.anode_sel  <= anode_d;
            bus.seven_seg  <= seg_d;
            bus.frame_done <= boundary;
        end
    end
endmodule
